// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
package button_debouncer_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

    // Gray-style encoding: every legal transition flips exactly one bit,
    // so outputs decoded from the state register cannot glitch.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b11,
        CHECK_LOW   = 2'b10
    } db_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign dout = sync2_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button: a level change is accepted only after
// DEBOUNCE_CYCLES consecutive stable synchronized samples.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_clean,
    output logic busy
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_2ff u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_in),
        .dout (btn_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LOW: begin
                if (btn_sync) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!btn_sync) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!btn_sync) begin
                    state_d = CHECK_LOW;
                    cnt_d   = '0;
                end
            end
            CHECK_LOW: begin
                if (btn_sync) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs; with the encoding above btn_clean is a direct flop bit.
    assign btn_clean = state_q[1];
    assign busy      = state_q[1] ^ state_q[0];

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES = 4.
module tb_button_debouncer;

    localparam int unsigned DC = 4;

    typedef struct {
        logic        val;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_clean;
    logic busy;

    exp_t        exp_q[$];
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned pulses   = 0;
    bit          mon_en   = 1'b0;
    logic        prev_clean;
    bit          have_last;
    int unsigned last_chg;

    button_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_clean (btn_clean),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input logic v, input int unsigned c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Drive a level and expect btn_clean to follow DC+2 edges after first sample.
    task automatic accept_level(input logic v);
        push_exp(v, cyc + 1 + DC + 2);
        btn_in = v;
        repeat (12) @(negedge clk);
    endtask

    // Monitor: every btn_clean change must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && (btn_clean !== prev_clean)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_clean_change", 32'(btn_clean), 32'(prev_clean));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("clean_value", 32'(btn_clean), 32'(e.val));
                check("clean_edge", cyc, e.cyc);
            end
            if (have_last)
                check("change_spacing_ok", 32'(((cyc - last_chg) >= DC + 1) ? 1 : 0), 1);
            if (btn_clean && !prev_clean) pulses++;
            have_last  = 1'b1;
            last_chg   = cyc;
            prev_clean = btn_clean;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        int unsigned done;
        rst    = 1'b0;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_clean", 32'(btn_clean), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b1;
        prev_clean = 1'b0;
        have_last  = 1'b0;
        mon_en     = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press with busy profile over edges e0..e0+7.
        e0 = cyc + 1;
        push_exp(1'b1, e0 + DC + 2);
        btn_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("press_busy_k%0d", k), 32'(busy),
                  ((cyc - e0) >= 2 && (cyc - e0) <= 5) ? 1 : 0);
        end
        repeat (4) @(negedge clk);

        // Release from STABLE_HIGH.
        accept_level(1'b0);

        // Bounce: 1,1,0 then held 1.
        btn_in = 1'b1;
        repeat (2) @(negedge clk);
        btn_in = 1'b0;
        @(negedge clk);
        accept_level(1'b1);
        accept_level(1'b0);

        // Short glitch of DC cycles never passes.
        btn_in = 1'b1;
        repeat (4) @(negedge clk);
        btn_in = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_clean", 32'(btn_clean), 0);
        check("glitch_busy", 32'(busy), 0);

        // Reset while qualifying a press.
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        check("midcheck_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("midcheck_rst_busy", 32'(busy), 0);
        check("midcheck_rst_clean", 32'(btn_clean), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_exp(1'b1, cyc + 1 + DC + 2);
        repeat (12) @(negedge clk);
        accept_level(1'b0);

        // Random short bursts never change the output.
        done = 0;
        while (done < 1000) begin
            int unsigned hi, lo;
            hi = $urandom_range(1, DC);
            lo = $urandom_range(1, 6);
            btn_in = 1'b1;
            repeat (hi) @(negedge clk);
            btn_in = 1'b0;
            repeat (lo) @(negedge clk);
            done += hi + lo;
        end
        repeat (10) @(negedge clk);
        check("random_clean", 32'(btn_clean), 0);
        check("random_busy", 32'(busy), 0);

        check("scoreboard_drained", exp_q.size(), 0);
        check("accepted_presses", pulses, 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16; number of consecutive stable synchronized samples needed to accept a level change; legal range 2..2^20.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserts immediately, releases synchronously to clk.
REQ-004 btn_in  input  1  raw mechanical push-button level, asynchronous to clk, may bounce.
REQ-005 btn_clean  output  1  debounced, glitch-free button level; drives the btn input of the downstream pulse generator.
REQ-006 busy  output  1  high while a candidate level change is being qualified (CHECK states).

Function
REQ-007 btn_in SHALL pass through a 2-flop synchronizer (sync1 -> sync2) before any other use; only sync2 reaches the FSM.
REQ-008 The FSM SHALL have four states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; any unused encoding SHALL go to STABLE_LOW on the next edge.
REQ-009 STABLE_LOW: sync2=0 -> stay; sync2=1 -> CHECK_HIGH with cnt cleared to 0.
REQ-010 CHECK_HIGH: sync2=0 -> STABLE_LOW, cnt cleared; sync2=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; sync2=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, cnt cleared.
REQ-011 STABLE_HIGH and CHECK_LOW SHALL mirror REQ-009/REQ-010 with polarities swapped.
REQ-012 btn_clean SHALL be a Moore output decoded from state only: 1 in STABLE_HIGH and CHECK_LOW, 0 in STABLE_LOW and CHECK_HIGH.
REQ-013 busy SHALL be 1 exactly in CHECK_HIGH and CHECK_LOW.
REQ-014 Latency: if btn_in is sampled 1 at edge E0 and stays 1, btn_clean SHALL rise after edge E0+DEBOUNCE_CYCLES+2; falling edge symmetric.
REQ-015 Any bounce (sync2 reverting) during a CHECK state SHALL abort the change with no glitch on btn_clean; qualification restarts from cnt=0 at the next transition.
REQ-016 Pulses of btn_in shorter than DEBOUNCE_CYCLES+1 clock periods SHALL never change btn_clean.
REQ-017 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.
REQ-018 btn_clean SHALL change at most once per DEBOUNCE_CYCLES+1 cycles.

Reset
REQ-019 On rst=0: sync1=0, sync2=0, cnt=0, state=STABLE_LOW, hence btn_clean=0, busy=0, asynchronously.
REQ-020 Reset asserted mid-CHECK SHALL discard the qualification; no output change is pending after release.
REQ-021 If btn_in is held 1 through reset release, btn_clean SHALL rise DEBOUNCE_CYCLES+2 edges after the first post-release edge.

Structure
REQ-022 A shared package SHALL hold the FSM state typedef (2-bit enum of the four states) and the DEBOUNCE_CYCLES default constant.
REQ-023 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, same clk/rst, reset value 0), instantiated once.
REQ-024 Next-state logic SHALL be combinational with a default assignment; state, cnt and synchronizer SHALL be the only flops.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Clean press: btn_in 0->1 before edge 0, held -> btn_clean=1 after edge 6, busy=1 after edges 2..5.
REQ-026 Bounce: btn_in 1 for 2 cycles, 0 for 1, then 1 held -> no btn_clean glitch; rises 6 edges after the final 0->1 sample.
REQ-027 Short glitch: btn_in 1 for 4 cycles then 0 -> btn_clean stays 0, busy returns to 0, state STABLE_LOW.
REQ-028 Release: from STABLE_HIGH, btn_in 1->0 held -> btn_clean falls after 6 edges; chained to the pulse generator, exactly one 1-cycle pulso per accepted press.
REQ-029 Reset mid-CHECK: assert rst during CHECK_HIGH -> btn_clean=0, busy=0 immediately; with btn_in held 1, btn_clean rises 6 edges after release.
REQ-030 Random bounce: 1000 cycles of random btn_in with bursts <5 cycles -> btn_clean never toggles; scoreboard checks REQ-018 spacing.
